// File: rtl/rv_mc_control.sv
// rv_mc_control -- multicycle RV32I control unit.
//
// Sequences one instruction at a time through FETCH / DECODE / execute /
// writeback states and drives the datapath selects and write enables.
// Memory accesses wait on mem_ready under a timeout. Illegal opcodes and
// timeouts park the FSM in TRAP until reset.
//
// Memory handshake: mem_req stays high for the whole access. The access
// completes in the first cycle where mem_req and mem_ready are both high.
// mem_we qualifies a request as a write, and mem_ctrl gives its size.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   op, funct3, funct7   instruction fields (only funct7[5] is used)
//   zero                 ALU zero flag for branch resolution
//   mem_ready            memory completes the current request
//   pc_we, ir_we, reg_we write enables (PC, IR, register file)
//   mem_req, mem_we      memory request and write qualifier
//   adr_src              0 = PC, 1 = ALUOut
//   mem_ctrl             access size (funct3 in data access, else word)
//   alu_src_a/b, alu_ctrl, res_src, imm_src   datapath selects
//   illegal, timeout     sticky trap causes
//   state_o              current state encoding (debug)

package rv_defs;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_TRAP     = 4'd11
  } mc_state_e;
endpackage

module rv_mc_control
  import rv_defs::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic [2:0] mem_ctrl,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic [1:0] res_src,
  output logic [2:0] imm_src,
  output logic       illegal,
  output logic       timeout,
  output logic [3:0] state_o
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  mc_state_e  state, next_state;
  logic [7:0] wait_cnt;
  logic       illegal_q, timeout_q;

  // Combinational decode results, gated by rst_n before reaching the ports.
  logic       pc_we_c, ir_we_c, reg_we_c, mem_req_c, mem_we_c, adr_src_c;
  logic [2:0] mem_ctrl_c, imm_src_c;
  logic [1:0] alu_src_a_c, alu_src_b_c, res_src_c;
  logic [3:0] alu_ctrl_c;
  logic       set_illegal, set_timeout, in_wait;

  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // funct7[5] selects SUB only for register-register ops; the I-type
  // immediate overlaps funct7, so it must be ignored there.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3,
                                         input logic       alt,
                                         input logic       is_reg);
    logic [3:0] r;
    case (f3)
      3'd0:    r = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    r = alt ? ALU_SRA : ALU_SRL;
      3'd6:    r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= next_state;
  end

  // The timeout fires in the cycle where the counter already equals
  // MEM_TIMEOUT and mem_ready is still low, so a ready in that same
  // cycle is still accepted as a normal completion.
  always_comb begin
    next_state  = state;
    pc_we_c     = 1'b0;
    ir_we_c     = 1'b0;
    reg_we_c    = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    adr_src_c   = 1'b0;
    mem_ctrl_c  = 3'b010;
    alu_src_a_c = 2'd0;
    alu_src_b_c = 2'd0;
    alu_ctrl_c  = ALU_ADD;
    res_src_c   = 2'd0;
    imm_src_c   = 3'd0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    in_wait     = 1'b0;

    case (state)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        in_wait   = 1'b1;
        if (mem_ready) begin
          ir_we_c     = 1'b1;
          pc_we_c     = 1'b1;
          alu_src_b_c = 2'd2;
          res_src_c   = 2'd2;
          next_state  = ST_DECODE;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          set_timeout = 1'b1;
          next_state  = ST_TRAP;
        end
      end
      ST_DECODE: begin
        alu_src_a_c = 2'd1;
        alu_src_b_c = 2'd1;
        imm_src_c   = 3'd2;
        case (op)
          OP_R:              next_state = ST_EXECR;
          OP_I:              next_state = ST_EXECI;
          OP_LOAD, OP_STORE: next_state = ST_MEMADR;
          OP_JAL:            next_state = ST_JAL;
          OP_BRANCH: begin
            if (funct3 == 3'd0 || funct3 == 3'd1) begin
              next_state = ST_BRANCH;
            end else begin
              set_illegal = 1'b1;
              next_state  = ST_TRAP;
            end
          end
          default: begin
            set_illegal = 1'b1;
            next_state  = ST_TRAP;
          end
        endcase
      end
      ST_MEMADR: begin
        alu_src_a_c = 2'd2;
        alu_src_b_c = 2'd1;
        imm_src_c   = (op == OP_STORE) ? 3'd1 : 3'd0;
        next_state  = (op == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
      end
      ST_MEMREAD, ST_MEMWRITE: begin
        mem_req_c  = 1'b1;
        mem_we_c   = (state == ST_MEMWRITE);
        adr_src_c  = 1'b1;
        mem_ctrl_c = funct3;
        in_wait    = 1'b1;
        if (mem_ready) begin
          next_state = (state == ST_MEMWRITE) ? ST_FETCH : ST_MEMWB;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          set_timeout = 1'b1;
          next_state  = ST_TRAP;
        end
      end
      ST_MEMWB: begin
        res_src_c  = 2'd1;
        reg_we_c   = 1'b1;
        next_state = ST_FETCH;
      end
      ST_EXECR, ST_EXECI: begin
        alu_src_a_c = 2'd2;
        alu_src_b_c = (state == ST_EXECI) ? 2'd1 : 2'd0;
        alu_ctrl_c  = alu_dec(funct3, funct7[5], state == ST_EXECR);
        next_state  = ST_ALUWB;
      end
      ST_ALUWB: begin
        reg_we_c   = 1'b1;
        next_state = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a_c = 2'd2;
        alu_ctrl_c  = ALU_SUB;
        pc_we_c     = (funct3 == 3'd0 && zero) || (funct3 == 3'd1 && !zero);
        next_state  = ST_FETCH;
      end
      ST_JAL: begin
        alu_src_a_c = 2'd1;
        alu_src_b_c = 2'd2;
        pc_we_c     = 1'b1;
        next_state  = ST_ALUWB;
      end
      ST_TRAP:  next_state = ST_TRAP;
      default: next_state = ST_TRAP;
    endcase
  end

  // Cleared on entry to any waiting state; counts cycles without ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (next_state != state &&
                 (next_state == ST_FETCH || next_state == ST_MEMREAD ||
                  next_state == ST_MEMWRITE)) begin
      wait_cnt <= 8'd0;
    end else if (in_wait && !mem_ready && wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  // Gating by rst_n makes every output drop in the same instant reset
  // asserts, so an aborted instruction never pulses a write enable.
  assign pc_we     = rst_n & pc_we_c;
  assign ir_we     = rst_n & ir_we_c;
  assign reg_we    = rst_n & reg_we_c;
  assign mem_req   = rst_n & mem_req_c;
  assign mem_we    = rst_n & mem_we_c;
  assign adr_src   = rst_n & adr_src_c;
  assign mem_ctrl  = rst_n ? mem_ctrl_c  : 3'd0;
  assign alu_src_a = rst_n ? alu_src_a_c : 2'd0;
  assign alu_src_b = rst_n ? alu_src_b_c : 2'd0;
  assign alu_ctrl  = rst_n ? alu_ctrl_c  : 4'd0;
  assign res_src   = rst_n ? res_src_c   : 2'd0;
  assign imm_src   = rst_n ? imm_src_c   : 3'd0;
  assign illegal   = illegal_q;
  assign timeout   = timeout_q;
  assign state_o   = rst_n ? state : 4'd0;

endmodule
